// File: rtl/usb_rx_unstuff_crc_if.sv
// Bus between the serial line decoder (master) and the USB receive unstuff/CRC5 checker (slave).
interface usb_rx_unstuff_crc_if #(
  parameter int unsigned MAX_BITS = 100,
  parameter int unsigned LEN_W    = $clog2(MAX_BITS + 1)
);
  logic                in_bit;
  logic                in_valid;
  logic [MAX_BITS-1:0] pkt_data;
  logic [LEN_W-1:0]    pkt_len;
  logic                pkt_done;
  logic                crc_ok;
  logic                pkt_err;
  logic                busy;

  modport master (
    output in_bit, in_valid,
    input  pkt_data, pkt_len, pkt_done, crc_ok, pkt_err, busy
  );

  modport slave (
    input  in_bit, in_valid,
    output pkt_data, pkt_len, pkt_done, crc_ok, pkt_err, busy
  );
endinterface

// File: rtl/usb_rx_unstuff_crc.sv
// USB receive path: removes stuffed zeros, captures the packet and checks the trailing CRC5.
// Define USB_RX_CRC_COMPL_EN to compare against the complemented (USB-compliant) remainder.
module usb_rx_unstuff_crc #(
  parameter int unsigned MAX_BITS = 100,
  parameter int unsigned LEN_W    = $clog2(MAX_BITS + 1)
) (
  input logic                 clock,
  input logic                 reset_n,
  usb_rx_unstuff_crc_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StPid, StData, StStuff, StEnd} state_e;

  state_e              state_q, state_d;
  logic [MAX_BITS-1:0] cap_q, cap_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [2:0]          ones_q, ones_d;
  logic [4:0]          hist_q, hist_d;
  logic [4:0]          lfsr_q, lfsr_d;
  logic                stuff_err_q, stuff_err_d;
  logic                ovf_q, ovf_d;

  logic [MAX_BITS-1:0] out_data_q;
  logic [LEN_W-1:0]    out_len_q;
  logic                out_crc_ok_q, out_err_q;

  logic       start, capture, finish;
  logic       eval_err, eval_crc_ok;
  logic [4:0] crc_exp;

  function automatic logic [4:0] lfsr_step(input logic [4:0] x, input logic b);
    logic fb;
    fb = b ^ x[4];
    return {x[3], x[2], x[1] ^ fb, x[0], fb};
  endfunction

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    len_d       = len_q;
    ones_d      = ones_q;
    hist_d      = hist_q;
    lfsr_d      = lfsr_q;
    stuff_err_d = stuff_err_q;
    ovf_d       = ovf_q;
    start       = 1'b0;
    capture     = 1'b0;
    finish      = 1'b0;

    unique case (state_q)
      StIdle, StEnd: begin
        state_d = StIdle;
        if (bus.in_valid) begin
          start   = 1'b1;
          state_d = StPid;
        end
      end
      StPid: begin
        if (!bus.in_valid) begin
          finish  = 1'b1;
          state_d = StEnd;
        end else begin
          capture = 1'b1;
          // PID bit 7 is the first bit that counts towards a stuffing run
          if (len_q == LEN_W'(7)) begin
            ones_d  = {2'b00, bus.in_bit};
            state_d = StData;
          end
        end
      end
      StData: begin
        if (!bus.in_valid) begin
          finish  = 1'b1;
          state_d = StEnd;
        end else begin
          capture = 1'b1;
          ones_d  = bus.in_bit ? ones_q + 3'd1 : 3'd0;
          if (ones_d == 3'd6) state_d = StStuff;
        end
      end
      StStuff: begin
        if (!bus.in_valid) begin
          finish  = 1'b1;
          state_d = StEnd;
        end else begin
          stuff_err_d = stuff_err_q | bus.in_bit;
          ones_d      = 3'd0;
          state_d     = StData;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      cap_d       = MAX_BITS'(bus.in_bit);
      len_d       = LEN_W'(1);
      ones_d      = 3'd0;
      hist_d      = {4'b0000, bus.in_bit};
      lfsr_d      = 5'b11111;
      stuff_err_d = 1'b0;
      ovf_d       = 1'b0;
    end else if (capture) begin
      if (len_q < LEN_W'(MAX_BITS)) begin
        cap_d  = cap_q | (MAX_BITS'(bus.in_bit) << len_q);
        len_d  = len_q + LEN_W'(1);
        hist_d = {hist_q[3:0], bus.in_bit};
        // CRC position is unknown until the end: feed the bit captured five positions ago
        if (len_q >= LEN_W'(13)) lfsr_d = lfsr_step(lfsr_q, hist_q[4]);
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_comb begin
`ifdef USB_RX_CRC_COMPL_EN
    crc_exp = ~lfsr_q;
`else
    crc_exp = lfsr_q;
`endif
    eval_err    = stuff_err_q | ovf_q | (len_q < LEN_W'(13));
    // hist_q[4] is the earliest of the last five bits, compared against x4
    eval_crc_ok = (hist_q == crc_exp) & ~eval_err;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cap_q       <= '0;
      len_q       <= '0;
      ones_q      <= 3'd0;
      hist_q      <= 5'd0;
      lfsr_q      <= 5'b11111;
      stuff_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      len_q       <= len_d;
      ones_q      <= ones_d;
      hist_q      <= hist_d;
      lfsr_q      <= lfsr_d;
      stuff_err_q <= stuff_err_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data_q   <= '0;
      out_len_q    <= '0;
      out_crc_ok_q <= 1'b0;
      out_err_q    <= 1'b0;
    end else if (finish) begin
      out_data_q   <= cap_q;
      out_len_q    <= len_q;
      out_crc_ok_q <= eval_crc_ok;
      out_err_q    <= eval_err;
    end
  end

  assign bus.pkt_data = out_data_q;
  assign bus.pkt_len  = out_len_q;
  assign bus.crc_ok   = out_crc_ok_q;
  assign bus.pkt_err  = out_err_q;
  assign bus.pkt_done = (state_q == StEnd);
  assign bus.busy     = (state_q == StPid) || (state_q == StData) || (state_q == StStuff);

endmodule

// File: doc/usb_rx_unstuff_crc.md
# usb_rx_unstuff_crc

Receive-side counterpart of the CRC5/bit-stuff transmit path. It accepts the serial USB bitstream, LSB-first, one bit per `in_valid` cycle, and removes stuffed zeros after every run of six ones. It captures the unstuffed bits into a parallel packet buffer and checks the trailing CRC5 over the bits that follow the PID. It sits between the line decoder (NRZI/serial front end) and the receive protocol handler; on packet end it reports `pkt_data`, `pkt_len`, `crc_ok` and `pkt_err`.

## Interface
- `MAX_BITS`, default 100: capacity of the packet buffer, in unstuffed bits.
- `LEN_W`, default `$clog2(MAX_BITS+1)`: width of `pkt_len`.
- `clock`  in  1  clock; all logic on posedge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `in_bit`  in  1  serial bit from the front end.
- `in_valid`  in  1  `in_bit` valid this cycle; stays high for the whole packet; first low cycle ends the packet.
- `pkt_data`  out  `MAX_BITS`  unstuffed bits; bit i = i-th received unstuffed bit; PID in [7:0].
- `pkt_len`  out  `LEN_W`  number of unstuffed bits captured, including PID and CRC.
- `pkt_done`  out  1  one-cycle strobe; outputs valid.
- `crc_ok`  out  1  CRC5 matched; 0 if `pkt_err`.
- `pkt_err`  out  1  stuff error, short packet (<13 bits) or overflow.
- `busy`  out  1  high from first valid bit until `pkt_done`.

## Operation
- FSM states:
  - IDLE: `in_valid`=1 → store bit 0, clear counters, go to PID.
  - PID: store bits 1..7. Bit 7 seeds the ones counter (1 if bit 7 is 1, else 0). After bit 7 → DATA.
  - DATA: store bit, update ones counter (1: +1; 0: clear). Reaching count 6 → STUFF.
  - STUFF: the next valid bit is discarded and not counted. If it is 1, set sticky stuff error. Clear ones counter → DATA.
  - `in_valid`=0 in PID, DATA or STUFF → END.
  - END: evaluate, pulse `pkt_done`, → IDLE.
- PID bits 0-6 are never ones-counted and never unstuffed.
- CRC5: LFSR x4..x0, initialised to 5'b11111 on packet start. Per data bit b:
  - x0←b^x4, x1←x0, x2←x1^(b^x4), x3←x2, x4←x3.
  - Position of the CRC is unknown until the end, so the LFSR is fed from a 5-bit history delay. The bit captured at index n is fed when index n+5 is captured, only for n≥8.
  - At END the LFSR has covered indices 8..len-6. The last 5 captured bits r0..r4 (r0 first received) are compared to {x4,x3,x2,x1,x0}.
- Overflow: bits beyond `MAX_BITS` are dropped, `pkt_len` saturates at `MAX_BITS`, and the overflow flag is set.
- `pkt_err` = stuff_err | overflow | (len<13). `crc_ok` = match & ~`pkt_err`.
- Outputs `pkt_data`, `pkt_len`, `crc_ok`, `pkt_err` are registered at END and held until the next END. Internal buffer writes do not disturb the held outputs (capture buffer is separate from the output register).
- Packet ending while in STUFF, with no stuff bit received: not an error.

## Timing
- Reset values: `pkt_data`=0, `pkt_len`=0, `pkt_done`=0, `crc_ok`=0, `pkt_err`=0, `busy`=0. FSM in IDLE, LFSR at 5'b11111.
- Latency: `pkt_done` is asserted in the cycle after the first `in_valid`=0 cycle, i.e. 2 edges after the last valid bit is sampled.
- `in_valid` may reassert in the `pkt_done` cycle: that bit is bit 0 of the next packet. The minimum inter-packet gap is 1 low cycle.
- `reset_n` asserted mid-packet: the packet is aborted immediately with no `pkt_done`, and all state returns to reset values.
- Single-cycle `in_valid` (1-bit packet): `pkt_done` with `pkt_len`=1 and `pkt_err`=1.

## Configuration
- `USB_RX_CRC_COMPL_EN`:
  - Defined: received CRC is compared against ~{x4..x0} (USB-compliant inverted CRC).
  - Undefined: compared against the raw remainder {x4..x0}, matching the current transmit CRC block, which sends the uncomplemented remainder.

## Test plan
- Clean token, macro undefined:
  - Stimulus: PID 8'hE1 (bits 1,0,0,0,0,1,1,1), 11 zero data bits, CRC bits 1,0,1,1,1, then `in_valid`=0.
  - Response: `pkt_done` 2 edges after the last bit; `pkt_len`=24; `pkt_data[7:0]`=8'hE1; `crc_ok`=1; `pkt_err`=0.
- Same stimulus with one data bit flipped → `crc_ok`=0, `pkt_err`=0. With `USB_RX_CRC_COMPL_EN`, CRC bits 0,1,0,0,0 → `crc_ok`=1.
- Stuffing:
  - Stimulus: PID 8'hE1, then data 1,1,1,1,1, stuffed 0, then more bits.
  - Response: the 0 is dropped; `pkt_len` excludes it; `pkt_data[12:8]`=5'b11111; next captured bit lands at index 13.
- Stuff error: 1 received where the stuff 0 is expected → `pkt_err`=1, `crc_ok`=0.
- Short packet and overflow:
  - 10-bit packet → `pkt_err`=1.
  - `MAX_BITS`+3 bits → `pkt_len`=`MAX_BITS`, `pkt_err`=1.
- Back-to-back and reset:
  - Two packets separated by 1 idle cycle → two `pkt_done` pulses with correct lengths.
  - `reset_n` low mid-packet → no `pkt_done`; all outputs 0.
